// File: rtl/score_accumulator.sv
// score_accumulator: two-team BCD score keeper for the basketball scoreboard.
// It takes one-cycle button pulses and possession levels from the debounce
// domain. Points are applied one BCD step per clock under a small FSM. Scores
// saturate at MAX_SCORE, and a clear pulse overrides every other input.
// Optional feature: define SCORE_UNDO_EN to add a one-entry undo history and a
// DEC state that takes back the last requested add.
module score_accumulator #(
    parameter int MAX_SCORE = 199
) (
    input  logic        clk_db,
    input  logic        rst,
    input  logic        clr_p,
    input  logic        add1_p,
    input  logic        add2_p,
    input  logic        add3_p,
    input  logic        poss_a,
    input  logic        poss_b,
    input  logic        undo_p,
    output logic [11:0] score_a,
    output logic [11:0] score_b,
    output logic [1:0]  poss,
    output logic        busy,
    output logic        done,
    output logic        drop
);

    // The saturation ceiling as three BCD digits. BCD values are ordered the
    // same way as their binary encodings, so a plain unsigned compare works.
    localparam logic [11:0] MAX_BCD = {4'(MAX_SCORE / 100),
                                       4'((MAX_SCORE / 10) % 10),
                                       4'(MAX_SCORE % 10)};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INC  = 2'd1
`ifdef SCORE_UNDO_EN
        ,
        DEC  = 2'd2
`endif
    } state_t;

    // Adds one to a 3-digit BCD value. The hundreds digit never overflows
    // because the caller saturates at MAX_SCORE, which is at most 999.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            if (v[7:4] == 4'd9) begin
                r[7:4]  = 4'd0;
                r[11:8] = v[11:8] + 4'd1;
            end else begin
                r[7:4] = v[7:4] + 4'd1;
            end
        end else begin
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

`ifdef SCORE_UNDO_EN
    // Subtracts one from a 3-digit BCD value. The caller never passes zero.
    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v[3:0] == 4'd0) begin
            r[3:0] = 4'd9;
            if (v[7:4] == 4'd0) begin
                r[7:4]  = 4'd9;
                r[11:8] = v[11:8] - 4'd1;
            end else begin
                r[7:4] = v[7:4] - 4'd1;
            end
        end else begin
            r[3:0] = v[3:0] - 4'd1;
        end
        return r;
    endfunction
`endif

    state_t            state_reg, state_next;
    logic [1:0]        count_reg, count_next;
    logic              team_reg, team_next;      // 0 = Team A, 1 = Team B
    logic [1:0][11:0]  score_reg, score_next;
    logic [1:0]        poss_reg, poss_next;
    logic              done_reg, done_next;
    logic              drop_reg, drop_next;

    logic              add_any;
    logic [1:0]        add_pts;
    logic              undo_req;

`ifdef SCORE_UNDO_EN
    logic              hist_valid_reg, hist_valid_next;
    logic              hist_team_reg, hist_team_next;
    logic [1:0]        hist_pts_reg, hist_pts_next;

    assign undo_req = undo_p;
`else
    // Undo requests are tied off in this build; the port is kept for pinout
    // compatibility only.
    assign undo_req = undo_p & 1'b0;
`endif

    // The largest simultaneous add wins.
    assign add_any = add1_p | add2_p | add3_p;
    assign add_pts = add3_p ? 2'd3 : (add2_p ? 2'd2 : 2'd1);

    // Possession decode: exactly one switch high selects a team.
    assign poss_next = (poss_a && !poss_b) ? 2'b01 :
                       (poss_b && !poss_a) ? 2'b10 : 2'b00;

    // State register: FSM, pending count, scores and flags.
    always_ff @(posedge clk_db or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= 2'd0;
            team_reg  <= 1'b0;
            score_reg <= '0;
            poss_reg  <= 2'b00;
            done_reg  <= 1'b0;
            drop_reg  <= 1'b0;
`ifdef SCORE_UNDO_EN
            hist_valid_reg <= 1'b0;
            hist_team_reg  <= 1'b0;
            hist_pts_reg   <= 2'd0;
`endif
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            team_reg  <= team_next;
            score_reg <= score_next;
            poss_reg  <= poss_next;
            done_reg  <= done_next;
            drop_reg  <= drop_next;
`ifdef SCORE_UNDO_EN
            hist_valid_reg <= hist_valid_next;
            hist_team_reg  <= hist_team_next;
            hist_pts_reg   <= hist_pts_next;
`endif
        end
    end

    // Next-state logic: clear first, then start, step and finish sequences.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        team_next  = team_reg;
        score_next = score_reg;
        done_next  = 1'b0;
        drop_next  = drop_reg;
`ifdef SCORE_UNDO_EN
        hist_valid_next = hist_valid_reg;
        hist_team_next  = hist_team_reg;
        hist_pts_next   = hist_pts_reg;
`endif

        if (clr_p) begin
            // A clear aborts any sequence silently; possession is untouched.
            state_next = IDLE;
            count_next = 2'd0;
            score_next = '0;
            drop_next  = 1'b0;
`ifdef SCORE_UNDO_EN
            hist_valid_next = 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (add_any && poss_reg != 2'b00) begin
                        count_next = add_pts;
                        team_next  = poss_reg[1];
                        state_next = INC;
`ifdef SCORE_UNDO_EN
                        // Record the requested points, even if saturation
                        // later discards some of them.
                        hist_valid_next = 1'b1;
                        hist_team_next  = poss_reg[1];
                        hist_pts_next   = add_pts;
`endif
                    end
`ifdef SCORE_UNDO_EN
                    else if (undo_req && hist_valid_reg) begin
                        count_next      = hist_pts_reg;
                        team_next       = hist_team_reg;
                        state_next      = DEC;
                        hist_valid_next = 1'b0;
                    end
`endif
                end
                INC: begin
                    if (add_any || undo_req) drop_next = 1'b1;
                    if (score_reg[team_reg] < MAX_BCD)
                        score_next[team_reg] = bcd_inc(score_reg[team_reg]);
                    count_next = count_reg - 2'd1;
                    if (count_reg == 2'd1) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
`ifdef SCORE_UNDO_EN
                DEC: begin
                    if (add_any || undo_req) drop_next = 1'b1;
                    if (score_reg[team_reg] != 12'h000)
                        score_next[team_reg] = bcd_dec(score_reg[team_reg]);
                    count_next = count_reg - 2'd1;
                    if (count_reg == 2'd1) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
`endif
                default: begin
                    state_next = IDLE;
                    count_next = 2'd0;
                end
            endcase
        end
    end

    assign score_a = score_reg[0];
    assign score_b = score_reg[1];
    assign poss    = poss_reg;
    assign busy    = (state_reg != IDLE);
    assign done    = done_reg;
    assign drop    = drop_reg;

endmodule
